// File: rtl/riscy_obi_mem_arbiter.sv
// riscy_obi_mem_arbiter: round-robin OBI arbiter merging fetch and load/store ports onto one memory with in-order response routing
module riscy_obi_mem_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [2:0]  outstanding_o,
  output logic        err_o
);
  localparam logic [2:0] MAX = 3'(MAX_OUTSTANDING);
  localparam logic [1:0] LAST = 2'(MAX_OUTSTANDING - 1);
  logic [3:0] fifo_q, fifo_d;
  logic [1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       err_q, err_d, last_q, last_d, lock_q, lock_d, owner_q, owner_d;
  logic       sel, full, empty, push, pop, head;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fifo_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b1;
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      fifo_q  <= fifo_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      last_q  <= last_d;
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end
  // Owner 0 is fetch, 1 is load/store; a stalled owner keeps the bus until granted or it withdraws
  always_comb begin
    sel = (lock_q && (owner_q ? data_req_i : instr_req_i)) ? owner_q :
          (instr_req_i && data_req_i) ? ~last_q : data_req_i;
    full  = cnt_q == MAX;
    empty = cnt_q == 3'd0;
    mem_req_o   = !rst_i && !full && (instr_req_i || data_req_i);
    mem_addr_o  = !mem_req_o ? 32'h0 : sel ? data_addr_i : instr_addr_i;
    mem_we_o    = mem_req_o && sel && data_we_i;
    mem_be_o    = !mem_req_o ? 4'h0 : sel ? data_be_i : 4'hF;
    mem_wdata_o = (mem_req_o && sel) ? data_wdata_i : 32'h0;
    instr_gnt_o = mem_req_o && mem_gnt_i && !sel;
    data_gnt_o  = mem_req_o && mem_gnt_i && sel;
    push = mem_req_o && mem_gnt_i;
    pop  = mem_rvalid_i && !empty;
    head = fifo_q[rptr_q];
    instr_rvalid_o = !rst_i && pop && !head;
    data_rvalid_o  = !rst_i && pop && head;
    instr_rdata_o  = mem_rdata_i;
    data_rdata_o   = mem_rdata_i;
    outstanding_o  = cnt_q;
    err_o          = err_q;
  end
  always_comb begin
    fifo_d = fifo_q;
    if (push) fifo_d[wptr_q] = sel;
    wptr_d  = !push ? wptr_q : (wptr_q == LAST) ? 2'd0 : wptr_q + 2'd1;
    rptr_d  = !pop ? rptr_q : (rptr_q == LAST) ? 2'd0 : rptr_q + 2'd1;
    cnt_d   = cnt_q + 3'(push) - 3'(pop);
    err_d   = err_q || (mem_rvalid_i && empty);
    last_d  = push ? sel : last_q;
    lock_d  = mem_req_o && !mem_gnt_i;
    owner_d = sel;
  end
endmodule

// File: tb/tb_riscy_obi_mem_arbiter.sv
// tb_riscy_obi_mem_arbiter: directed stimulus with a queue-based reference model checked every cycle
module tb_riscy_obi_mem_arbiter;
  localparam int MAXO = 2;
  logic        clk_i = 1'b0, rst_i;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [2:0]  outstanding_o;
  logic        err_o;
  int n_cmp = 0, n_bad = 0;

  riscy_obi_mem_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    instr_req_i = 0; data_req_i = 0; data_we_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
  endtask

  // Reference model: queue of owners awaiting a response (0 fetch, 1 data)
  int q[$];
  bit m_last_data = 1'b1;
  int m_lock = -1;
  bit m_err = 1'b0;
  int own;
  bit ereq, hv;
  always @(negedge clk_i) begin
    if (rst_i) begin
      chk("rst_igt", instr_gnt_o, 0);
      chk("rst_dgt", data_gnt_o, 0);
      chk("rst_irv", instr_rvalid_o, 0);
      chk("rst_drv", data_rvalid_o, 0);
      q.delete();
      m_last_data = 1'b1;
      m_lock = -1;
      m_err = 1'b0;
    end else begin
      if (m_lock >= 0 && (m_lock == 0 ? instr_req_i : data_req_i)) own = m_lock;
      else if (instr_req_i && data_req_i) own = m_last_data ? 0 : 1;
      else if (instr_req_i) own = 0;
      else if (data_req_i) own = 1;
      else own = -1;
      ereq = q.size() < MAXO && own >= 0;
      chk("m_req", mem_req_o, ereq);
      chk("m_addr", mem_addr_o, ereq ? (own == 0 ? instr_addr_i : data_addr_i) : 32'h0);
      if (ereq) begin
        chk("m_we", mem_we_o, own == 1 && data_we_i);
        chk("m_be", mem_be_o, own == 1 ? data_be_i : 4'hF);
        chk("m_wdata", mem_wdata_o, own == 1 ? data_wdata_i : 32'h0);
      end
      chk("m_igt", instr_gnt_o, ereq && mem_gnt_i && own == 0);
      chk("m_dgt", data_gnt_o, ereq && mem_gnt_i && own == 1);
      hv = mem_rvalid_i && q.size() > 0;
      chk("m_irv", instr_rvalid_o, hv && q[0] == 0);
      chk("m_drv", data_rvalid_o, hv && q[0] == 1);
      chk("m_irdata", instr_rdata_o, mem_rdata_i);
      chk("m_drdata", data_rdata_o, mem_rdata_i);
      chk("m_out", outstanding_o, q.size());
      chk("m_err", err_o, m_err);
      if (mem_rvalid_i) begin
        if (q.size() > 0) void'(q.pop_front());
        else m_err = 1'b1;
      end
      if (ereq && mem_gnt_i) begin
        q.push_back(own);
        m_last_data = own == 1;
      end
      m_lock = (ereq && !mem_gnt_i) ? own : -1;
    end
  end

  initial begin
    rst_i = 1; idle();
    instr_addr_i = 0; data_addr_i = 0; data_be_i = 0; data_wdata_i = 0; mem_rdata_i = 0;
    step(); step(); rst_i = 0;
    @(negedge clk_i);
    chk("rst_out", outstanding_o, 0);
    chk("rst_err", err_o, 0);
    chk("idle_req", mem_req_o, 0);
    chk("idle_addr", mem_addr_o, 0);
    // lone fetch, response two cycles later
    step(); instr_req_i = 1; instr_addr_i = 32'h80; mem_gnt_i = 1;
    @(negedge clk_i);
    chk("t1_gnt", instr_gnt_o, 1);
    chk("t1_addr", mem_addr_o, 32'h80);
    chk("t1_be", mem_be_o, 4'hF);
    step(); idle();
    step(); mem_rvalid_i = 1; mem_rdata_i = 32'h13;
    @(negedge clk_i);
    chk("t1_irv", instr_rvalid_o, 1);
    chk("t1_rdata", instr_rdata_o, 32'h13);
    chk("t1_drv", data_rvalid_o, 0);
    step(); idle();
    // continuous contention alternates owners
    rst_i = 1; step(); rst_i = 0;
    for (int i = 0; i < 5; i++) begin
      instr_req_i = i < 4; data_req_i = i < 4; mem_gnt_i = i < 4; mem_rvalid_i = i >= 1;
      instr_addr_i = 32'h200 + i; data_addr_i = 32'h300 + i; data_be_i = 4'hF; mem_rdata_i = 32'h1000 + i;
      @(negedge clk_i);
      if (i < 4) begin
        chk("t2_igt", instr_gnt_o, i % 2 == 0);
        chk("t2_dgt", data_gnt_o, i % 2 == 1);
      end
      if (i >= 1) begin
        chk("t2_irv", instr_rvalid_o, (i - 1) % 2 == 0);
        chk("t2_drv", data_rvalid_o, (i - 1) % 2 == 1);
      end
      step();
    end
    idle();
    // stalled store holds the bus while fetch waits
    for (int i = 0; i < 4; i++) begin
      data_req_i = 1; data_we_i = 1; data_be_i = 4'h3; data_addr_i = 32'h100; data_wdata_i = 32'hDEADBEEF;
      instr_req_i = i >= 1; instr_addr_i = 32'h400; mem_gnt_i = i == 3;
      @(negedge clk_i);
      chk("t3_addr", mem_addr_o, 32'h100);
      chk("t3_wdata", mem_wdata_o, 32'hDEADBEEF);
      chk("t3_be", mem_be_o, 4'h3);
      chk("t3_we", mem_we_o, 1);
      chk("t3_dgt", data_gnt_o, i == 3);
      chk("t3_igt", instr_gnt_o, 0);
      step();
    end
    data_req_i = 0; data_we_i = 0; mem_gnt_i = 1;
    @(negedge clk_i);
    chk("t3_igt_after", instr_gnt_o, 1);
    chk("t3_addr_after", mem_addr_o, 32'h400);
    chk("t3_we_after", mem_we_o, 0);
    step();
    // full: issue blocked even with a response in the same cycle
    data_req_i = 1; data_addr_i = 32'h500; mem_rvalid_i = 1; mem_rdata_i = 32'hAA;
    @(negedge clk_i);
    chk("t4_out", outstanding_o, 2);
    chk("t4_req", mem_req_o, 0);
    chk("t4_igt", instr_gnt_o, 0);
    chk("t4_dgt", data_gnt_o, 0);
    chk("t4_drv", data_rvalid_o, 1);
    step(); mem_rvalid_i = 0;
    @(negedge clk_i);
    chk("t4_out1", outstanding_o, 1);
    chk("t4_resume", data_gnt_o, 1);
    step(); idle();
    @(negedge clk_i);
    chk("t6_out2", outstanding_o, 2);
    // reset with transactions in flight, then a stale response
    step(); rst_i = 1; step(); rst_i = 0; mem_rvalid_i = 1;
    @(negedge clk_i);
    chk("t6_out0", outstanding_o, 0);
    chk("t6_irv", instr_rvalid_o, 0);
    chk("t6_drv", data_rvalid_o, 0);
    step(); mem_rvalid_i = 0;
    @(negedge clk_i);
    chk("t6_err", err_o, 1);
    step(); step();
    @(negedge clk_i);
    chk("t5_sticky", err_o, 1);
    step(); rst_i = 1; step(); rst_i = 0;
    @(negedge clk_i);
    chk("t5_clr", err_o, 0);
    step(); mem_rvalid_i = 1; step(); mem_rvalid_i = 0;
    @(negedge clk_i);
    chk("t5_err", err_o, 1);
    // locked owner withdraws: lock drops and the other side wins
    step(); rst_i = 1; step(); rst_i = 0; data_req_i = 1; data_addr_i = 32'h600; mem_gnt_i = 0;
    @(negedge clk_i);
    chk("t7_dgt", data_gnt_o, 0);
    step(); data_req_i = 0; instr_req_i = 1; instr_addr_i = 32'h700; mem_gnt_i = 1;
    @(negedge clk_i);
    chk("t7_igt", instr_gnt_o, 1);
    chk("t7_addr", mem_addr_o, 32'h700);
    step(); idle();
    @(negedge clk_i);
    chk("t7_out", outstanding_o, 1);
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
